cart_ram_arbiter: RTL
=====================

// Module: cart_ram_arbiter
// PURPOSE
//  Single-port cart RAM scheduler between the mapper bank and the cart RAM.
//  Shares one 8-bit synchronous RAM port between three requesters:
//    - CPU cart-RAM access (A000-BFFF)
//    - mapper direct writes (MBC7 EEPROM)
//    - 16-bit save-file backup load/store
//  Backup words are sequenced as two byte accesses. CPU timing is never disturbed.
// PARAMETERS
//  ADDR_W   17  cart RAM byte address width
//  RAM_LAT  1   RAM read latency in clk_sys cycles (1..2)
// PORTS
//  clk_sys     in   1       system clock
//  reset       in   1       synchronous, active-high
//  ce_cpu      in   1       CPU access slot strobe
//  cpu_req     in   1       CPU cart-RAM access valid (sampled on ce_cpu)
//  cpu_wr      in   1       1=write, 0=read
//  cpu_addr    in   ADDR_W  CPU byte address
//  cpu_wdata   in   8       CPU write data
//  cpu_rdata   out  8       CPU read data; holds until next CPU read completes
//  map_wr      in   1       mapper write strobe (1 cycle)
//  map_addr    in   ADDR_W  mapper write address
//  map_wdata   in   8       mapper write data
//  map_busy    out  1       mapper write pending
//  bk_rd       in   1       backup word read strobe
//  bk_wr       in   1       backup word write strobe
//  bk_addr     in   ADDR_W-1  backup word address; byte = {bk_addr,lo/hi}
//  bk_data     in   16      backup write word; [7:0]=even byte
//  bk_q        out  16      backup read word
//  bk_ack      out  1       1-cycle completion pulse
//  bk_busy     out  1       backup sequencer not idle
//  ram_addr    out  ADDR_W  RAM address (registered)
//  ram_wdata   out  8       RAM write data (registered)
//  ram_we      out  1       RAM write enable (registered)
//  ram_q       in   8       RAM read data, valid RAM_LAT cycles after ram_addr
// BEHAVIOUR
//  - Reset values: every output 0; map pending cleared; sequencer in IDLE.
//  - Arbitration each cycle: CPU (ce_cpu&cpu_req) > mapper pending > backup.
//    Winner's address/data/we registered onto ram_* next cycle.
//    With no winner: ram_we=0, ram_addr held.
//  - CPU read: cpu_rdata <= ram_q exactly 1+RAM_LAT cycles after the ce_cpu cycle.
//  - Mapper: map_wr loads the 1-deep pending slot and sets map_busy.
//    The slot drains on the first non-CPU cycle. map_wr on that drain cycle
//    reloads the slot. map_wr while busy overwrites the slot (last write wins).
//  - Backup FSM:
//    IDLE -(bk_wr|bk_rd)-> LO -(granted)-> HI -(granted)-> WAIT -> DONE -> IDLE
//    bk_wr takes priority when bk_wr and bk_rd are both high.
//    Address and data are latched on entry.
//    WAIT counts RAM_LAT cycles for the read (skipped for writes).
//    Read bytes are captured into bk_q[7:0] / bk_q[15:8].
//    DONE pulses bk_ack for 1 cycle.
//    bk_busy is high outside IDLE; strobes arriving when not IDLE are ignored.
//  - LO/HI stall while a higher requester wins; there is no timeout.
//  - A CPU write in the same cycle as the backup targets the same byte: CPU wins;
//    the backup byte is written later and its value persists (documented hazard).
//  - Reset asserted mid-word: FSM goes to IDLE with no bk_ack; a partially
//    written word stays partial; ram_we is deasserted next cycle.
// CONFIGURATION
//  CART_RAM_STALL_CNT_EN defined:
//    adds out stall_cnt[15:0], a saturating count of cycles the FSM spent in
//    LO/HI without a grant; cleared by reset.
//  CART_RAM_STALL_CNT_EN undefined:
//    the port and the counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Package cart_ram_pkg holds:
//    grant_t enum {GNT_NONE, GNT_CPU, GNT_MAP, GNT_BK},
//    bk_state_t enum {IDLE, LO, HI, WAIT, DONE}, and CRAM_ADDR_W=17.
//  - Sub-module cart_ram_bk_seq: backup FSM plus word latch; it exposes
//    byte req/addr/wdata/we and takes a grant. The arbiter keeps priority,
//    the mapper slot and the RAM output registers.
// TESTING
//  1 reset -> all outputs 0, bk_busy=0.
//    Then bk_wr addr=0x0010 data=0xBEEF -> RAM[0x20]=EF, RAM[0x21]=BE,
//    one bk_ack.
//  2 bk_rd addr=0x0010 after test 1 -> bk_q=0xBEEF with bk_ack;
//    repeat with RAM_LAT=2 -> same result, 1 cycle later.
//  3 ce_cpu every cycle during a bk_wr -> no ram_we from backup until
//    ce_cpu drops; every CPU read returns correct data at 1+RAM_LAT.
//  4 map_wr 0x100=0x5A, then map_wr 0x100=0xA5 while busy ->
//    single RAM write of 0xA5; map_busy clears after the drain.
//  5 reset asserted between the LO and HI writes -> lo byte written,
//    hi byte untouched, no bk_ack, FSM in IDLE.
//  6 with CART_RAM_STALL_CNT_EN: a 5-cycle CPU block during LO -> stall_cnt=5;
//    forcing 70000 stalled cycles -> stall_cnt=0xFFFF.

Source files
------------

// File: rtl/cart_ram_pkg.sv
// Cart RAM arbiter shared definitions.
//   grant_t     : which requester owns the RAM port in a given cycle
//   bk_state_t  : backup word sequencer states
//   CRAM_ADDR_W : default cart RAM byte address width
package cart_ram_pkg;

    localparam int CRAM_ADDR_W = 17;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_MAP,
        GNT_BK
    } grant_t;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        WAIT,
        DONE
    } bk_state_t;

endpackage

// File: rtl/cart_ram_bk_seq.sv
// Backup word sequencer: splits one 16-bit save-file load/store into two byte
// accesses (even byte first) on the shared cart RAM port.
// Ports:
//   clk_sys, reset        clock, synchronous active-high reset
//   bk_rd, bk_wr          word strobes, accepted only in IDLE (write wins)
//   bk_addr, bk_data      word address / write word, latched on acceptance
//   ram_q                 RAM read data
//   byte_gnt              arbiter grant for the byte request this cycle
//   byte_req/addr/wdata/we  byte access request towards the arbiter
//   bk_q, bk_ack          read word and 1-cycle completion pulse (registered)
//   state_dbg             current sequencer state
//   stall_cnt             only with CART_RAM_STALL_CNT_EN: saturating count of
//                         LO/HI cycles without a grant
module cart_ram_bk_seq
    import cart_ram_pkg::*;
#(
    parameter int ADDR_W  = CRAM_ADDR_W,
    parameter int RAM_LAT = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              bk_rd,
    input  logic              bk_wr,
    input  logic [ADDR_W-2:0] bk_addr,
    input  logic [15:0]       bk_data,
    input  logic [7:0]        ram_q,
    input  logic              byte_gnt,
    output logic              byte_req,
    output logic [ADDR_W-1:0] byte_addr,
    output logic [7:0]        byte_wdata,
    output logic              byte_we,
    output logic [15:0]       bk_q,
    output logic              bk_ack,
    output logic [2:0]        state_dbg
`ifdef CART_RAM_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [1:0] WAIT_LAST = 2'(RAM_LAT - 1);

    bk_state_t         state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic [1:0]        wait_q, wait_d;
    logic [RAM_LAT:0]  lo_pipe_q, lo_pipe_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              ack_q, ack_d;

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wait_d     = wait_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        lo_pipe_d  = {lo_pipe_q[RAM_LAT-1:0], 1'b0};
        byte_req   = 1'b0;
        byte_we    = 1'b0;
        byte_addr  = {addr_q, 1'b0};
        byte_wdata = data_q[7:0];

        // The low byte may be granted long before the high byte, so its read
        // data is picked up by its own latency pipe rather than by the FSM.
        if (lo_pipe_q[RAM_LAT]) begin
            rdata_d[7:0] = ram_q;
        end

        case (state_q)
            IDLE: begin
                if (bk_wr || bk_rd) begin
                    wr_d    = bk_wr;
                    addr_d  = bk_addr;
                    data_d  = bk_data;
                    state_d = LO;
                end
            end
            LO: begin
                byte_req = 1'b1;
                byte_we  = wr_q;
                if (byte_gnt) begin
                    lo_pipe_d[0] = ~wr_q;
                    state_d      = HI;
                end
            end
            HI: begin
                byte_req   = 1'b1;
                byte_we    = wr_q;
                byte_addr  = {addr_q, 1'b1};
                byte_wdata = data_q[15:8];
                if (byte_gnt) begin
                    wait_d  = 2'd0;
                    state_d = wr_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            DONE: begin
                // WAIT lasted exactly RAM_LAT cycles, so ram_q now holds the
                // high byte; it is registered together with the ack pulse.
                if (!wr_q) begin
                    rdata_d[15:8] = ram_q;
                end
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wait_q    <= '0;
            lo_pipe_q <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wait_q    <= wait_d;
            lo_pipe_q <= lo_pipe_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
        end
    end

    assign bk_q      = rdata_q;
    assign bk_ack    = ack_q;
    assign state_dbg = state_q;

`ifdef CART_RAM_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == LO || state_q == HI) && !byte_gnt && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: rtl/cart_ram_arbiter.sv
// Single-port cart RAM scheduler. Shares one registered 8-bit RAM port
// between CPU accesses (highest priority, never delayed), a 1-deep mapper
// write slot and the backup word sequencer (lowest priority).
// Ports:
//   clk_sys, reset                    clock, synchronous active-high reset
//   ce_cpu, cpu_req, cpu_wr,
//   cpu_addr, cpu_wdata, cpu_rdata    CPU slot; read data lands 1+RAM_LAT
//                                     cycles after the ce_cpu cycle and holds
//   map_wr, map_addr, map_wdata,
//   map_busy                          mapper write slot (last write wins)
//   bk_rd, bk_wr, bk_addr, bk_data,
//   bk_q, bk_ack, bk_busy             backup word interface
//   ram_addr, ram_wdata, ram_we, ram_q registered RAM port
//   stall_cnt                         only with CART_RAM_STALL_CNT_EN
// Handshake: requests are level/strobe, no ready; the backup side signals
// completion with a single bk_ack pulse and ignores strobes while bk_busy.
module cart_ram_arbiter
    import cart_ram_pkg::*;
#(
    parameter int ADDR_W  = CRAM_ADDR_W,
    parameter int RAM_LAT = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_cpu,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    input  logic              map_wr,
    input  logic [ADDR_W-1:0] map_addr,
    input  logic [7:0]        map_wdata,
    output logic              map_busy,
    input  logic              bk_rd,
    input  logic              bk_wr,
    input  logic [ADDR_W-2:0] bk_addr,
    input  logic [15:0]       bk_data,
    output logic [15:0]       bk_q,
    output logic              bk_ack,
    output logic              bk_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_q
`ifdef CART_RAM_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    grant_t            gnt;
    logic              cpu_go;
    logic              bk_req;
    logic              bk_we;
    logic [ADDR_W-1:0] bk_byte_addr;
    logic [7:0]        bk_byte_wdata;
    logic [2:0]        bk_state_dbg;

    logic              map_pend_q, map_pend_d;
    logic [ADDR_W-1:0] map_addr_q, map_addr_d;
    logic [7:0]        map_data_q, map_data_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic [RAM_LAT:0]  rd_pipe_q, rd_pipe_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;

    cart_ram_bk_seq #(
        .ADDR_W  (ADDR_W),
        .RAM_LAT (RAM_LAT)
    ) u_bk_seq (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .bk_rd      (bk_rd),
        .bk_wr      (bk_wr),
        .bk_addr    (bk_addr),
        .bk_data    (bk_data),
        .ram_q      (ram_q),
        .byte_gnt   (gnt == GNT_BK),
        .byte_req   (bk_req),
        .byte_addr  (bk_byte_addr),
        .byte_wdata (bk_byte_wdata),
        .byte_we    (bk_we),
        .bk_q       (bk_q),
        .bk_ack     (bk_ack),
        .state_dbg  (bk_state_dbg)
`ifdef CART_RAM_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    assign cpu_go = ce_cpu & cpu_req;

    always_comb begin
        gnt = GNT_NONE;
        if (cpu_go) begin
            gnt = GNT_CPU;
        end else if (map_pend_q) begin
            gnt = GNT_MAP;
        end else if (bk_req) begin
            gnt = GNT_BK;
        end
    end

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        case (gnt)
            GNT_CPU: begin
                ram_addr_d  = cpu_addr;
                ram_wdata_d = cpu_wdata;
                ram_we_d    = cpu_wr;
            end
            GNT_MAP: begin
                ram_addr_d  = map_addr_q;
                ram_wdata_d = map_data_q;
                ram_we_d    = 1'b1;
            end
            GNT_BK: begin
                ram_addr_d  = bk_byte_addr;
                ram_wdata_d = bk_byte_wdata;
                ram_we_d    = bk_we;
            end
            default: ;
        endcase
    end

    // A new map_wr always lands in the slot, even on the cycle the old
    // contents drain, so the slot stays pending with the newer write.
    always_comb begin
        map_pend_d = map_pend_q;
        map_addr_d = map_addr_q;
        map_data_d = map_data_q;
        if (gnt == GNT_MAP) begin
            map_pend_d = 1'b0;
        end
        if (map_wr) begin
            map_pend_d = 1'b1;
            map_addr_d = map_addr;
            map_data_d = map_wdata;
        end
    end

    // rd_pipe[k] is set k+1 cycles after a CPU read slot; the RAM data for
    // that read is on ram_q while rd_pipe[RAM_LAT] is set.
    always_comb begin
        rd_pipe_d   = {rd_pipe_q[RAM_LAT-1:0], cpu_go & ~cpu_wr};
        cpu_rdata_d = cpu_rdata_q;
        if (rd_pipe_q[RAM_LAT]) begin
            cpu_rdata_d = ram_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            map_pend_q  <= 1'b0;
            map_addr_q  <= '0;
            map_data_q  <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            rd_pipe_q   <= '0;
            cpu_rdata_q <= '0;
        end else begin
            map_pend_q  <= map_pend_d;
            map_addr_q  <= map_addr_d;
            map_data_q  <= map_data_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            rd_pipe_q   <= rd_pipe_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign cpu_rdata = cpu_rdata_q;
    assign map_busy  = map_pend_q;
    assign bk_busy   = (bk_state_dbg != IDLE);

endmodule
